pattern_detector_param: RTL and testbench

- Parametrised successor to the fixed 4-byte "bomb" detector.
- Scans a byte stream, gated by `data_valid`, for a runtime-programmable pattern of 1..MAX_LEN symbols.
- Supports overlapping or non-overlapping matching, counts matches, and holds `found_pattern` until acknowledged.
- Sits between the byte-stream source and the control/status block that services `ack`.

---
 rtl/pattern_det_pkg.sv | 18 +
 rtl/pattern_det_history.sv | 63 ++++++
 rtl/pattern_detector_param.sv | 125 ++++++++++++
 tb/tb_pattern_detector_param.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_det_pkg.sv
// Shared types, default widths and helpers for the parametrised pattern detector.
package pattern_det_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StHit  = 2'd2
  } state_e;

  localparam int unsigned DefDataW  = 8;
  localparam int unsigned DefMaxLen = 8;
  localparam int unsigned DefCntW   = 16;

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/pattern_det_history.sv
// Symbol history shift register with fill counter and parallel compare against the pattern.
module pattern_det_history
  import pattern_det_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned MAX_LEN = DefMaxLen
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clear_i,
  input  logic                              shift_i,
  input  logic                              flush_i,
  input  logic [DATA_W-1:0]                 data_i,
  input  logic [MAX_LEN-1:0][DATA_W-1:0]    pat_i,
  input  logic [$clog2(MAX_LEN+1)-1:0]      len_i,
  output logic                              match_o
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned IDX_W = $clog2(MAX_LEN);

  // Entry 0 is the most recently accepted symbol.
  logic [MAX_LEN-1:0][DATA_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]               fill_q, fill_d, fill_nx;
  logic [IDX_W-1:0]               pat_idx;
  logic                           match;

  always_comb begin
    hist_d  = hist_q;
    fill_nx = fill_q;
    pat_idx = '0;
    if (shift_i) begin
      hist_d = {hist_q[MAX_LEN-2:0], data_i};
      if (32'(fill_q) < MAX_LEN) fill_nx = fill_q + 1'b1;
    end

    // Newest symbol lines up with the last pattern slot, older ones walk backwards.
    match = 1'b0;
    if (shift_i && (len_i != '0) && (fill_nx >= len_i)) begin
      match = 1'b1;
      for (int unsigned j = 0; j < MAX_LEN; j++) begin
        pat_idx = IDX_W'(len_i - LEN_W'(j) - 1'b1);
        if ((j < 32'(len_i)) && (hist_d[IDX_W'(j)] != pat_i[pat_idx])) match = 1'b0;
      end
    end

    fill_d = fill_nx;
    if (clear_i || (flush_i && match)) fill_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign match_o = match;

endmodule

// File: rtl/pattern_detector_param.sv
// Programmable stream pattern detector: FSM, pattern RAM, match counter and ack handshake.
module pattern_detector_param
  import pattern_det_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned MAX_LEN = DefMaxLen,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned CNT_W   = DefCntW,
  parameter bit          OVERLAP = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset_sync,
  input  logic                       enable,
  input  logic                       cfg_we,
  input  logic [$clog2(MAX_LEN)-1:0] cfg_idx,
  input  logic [DATA_W-1:0]          cfg_byte,
  input  logic [LEN_W-1:0]           cfg_len,
  input  logic                       data_valid,
  input  logic [DATA_W-1:0]          data,
  input  logic                       ack,
  output logic                       found_pattern,
  output logic [CNT_W-1:0]           match_count,
  output logic                       pend_hit
);

  state_e                         state_q, state_d;
  logic [LEN_W-1:0]               len_q, len_d;
  logic [MAX_LEN-1:0][DATA_W-1:0] pat_q, pat_d;
  logic                           found_q, found_d;
  logic                           pend_q, pend_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d, cnt_inc;
  logic                           scan_on, hist_clear, match_next;

  assign scan_on = enable && (state_q != StIdle);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  pattern_det_history #(
    .DATA_W  (DATA_W),
    .MAX_LEN (MAX_LEN)
  ) u_history (
    .clk_i   (clk),
    .rst_ni  (reset_sync),
    .clear_i (hist_clear),
    .shift_i (scan_on && data_valid),
    .flush_i (OVERLAP == 1'b0),
    .data_i  (data),
    .pat_i   (pat_q),
    .len_i   (len_q),
    .match_o (match_next)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    pat_d      = pat_q;
    found_d    = found_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    hist_clear = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          len_d      = LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
          hist_clear = 1'b1;
          cnt_d      = '0;
          state_d    = StScan;
        end else if (cfg_we && (32'(cfg_idx) < MAX_LEN)) begin
          pat_d[cfg_idx] = cfg_byte;
        end
      end
      StScan: begin
        if (match_next) begin
          found_d = 1'b1;
          cnt_d   = cnt_inc;
          state_d = StHit;
        end
      end
      StHit: begin
        if (match_next) cnt_d = cnt_inc;
        // HIT with found low is the one-cycle gap before a pending match is re-raised.
        if (!found_q) begin
          found_d = 1'b1;
          if (match_next) pend_d = 1'b1;
        end else if (ack) begin
          found_d = 1'b0;
          pend_d  = 1'b0;
          if (!(pend_q || match_next)) state_d = StScan;
        end else if (match_next) begin
          pend_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!enable && (state_q != StIdle)) begin
      state_d = StIdle;
      found_d = 1'b0;
      pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_sync) begin
    if (!reset_sync) begin
      state_q <= StIdle;
      len_q   <= '0;
      pat_q   <= '0;
      found_q <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      found_q <= found_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign found_pattern = found_q;
  assign match_count   = cnt_q;
  assign pend_hit      = pend_q;

endmodule

// File: tb/tb_pattern_detector_param.sv
// Bench for pattern_detector_param: overlapping and non-overlapping instances share one stimulus.
module tb_pattern_detector_param;

  localparam int ML = 8;
  localparam int LW = 4;
  localparam int CW = 16;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset_sync = 1'b0;
  logic          enable = 1'b0;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [7:0]    cfg_byte = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          data_valid = 1'b0;
  logic [7:0]    data = '0;
  logic          ack = 1'b0;
  logic          found [2];
  logic [CW-1:0] cnt [2];
  logic          pend [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pattern_detector_param #(.OVERLAP(1'b1)) dut_ov (
    .clk(clk), .reset_sync(reset_sync), .enable(enable), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_byte(cfg_byte), .cfg_len(cfg_len), .data_valid(data_valid), .data(data), .ack(ack),
    .found_pattern(found[0]), .match_count(cnt[0]), .pend_hit(pend[0])
  );

  pattern_detector_param #(.OVERLAP(1'b0)) dut_no (
    .clk(clk), .reset_sync(reset_sync), .enable(enable), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_byte(cfg_byte), .cfg_len(cfg_len), .data_valid(data_valid), .data(data), .ack(ack),
    .found_pattern(found[1]), .match_count(cnt[1]), .pend_hit(pend[1])
  );

  // Reference model: a log of every accepted symbol; each instance remembers where its
  // usable history starts (enable rise, reset, or a flushing match).
  logic [7:0] m_pat [ML];
  logic [7:0] m_log [8192];
  int         m_len, m_n;
  int         m_start [2];
  int         m_cnt [2];
  bit         m_found [2], m_pend [2], m_rearm [2];
  bit         m_run;

  task automatic m_reset();
    for (int i = 0; i < ML; i++) m_pat[i] = 8'h00;
    m_len = 0;
    m_run = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_start[d] = m_n; m_cnt[d] = 0;
      m_found[d] = 1'b0; m_pend[d] = 1'b0; m_rearm[d] = 1'b0;
    end
  endtask

  function automatic bit m_hit(input int d);
    if (m_len == 0 || (m_n - m_start[d]) < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++)
      if (m_log[13'(m_n - m_len + i)] != m_pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_step();
    bit hit;
    if (!reset_sync) begin
      m_reset();
      return;
    end
    if (!m_run) begin
      if (enable) begin
        m_len = (int'(cfg_len) > ML) ? ML : int'(cfg_len);
        for (int d = 0; d < 2; d++) begin m_start[d] = m_n; m_cnt[d] = 0; end
        m_run = 1'b1;
      end else if (cfg_we) begin
        m_pat[cfg_idx] = cfg_byte;
      end
    end else if (!enable) begin
      m_run = 1'b0;
      for (int d = 0; d < 2; d++) begin
        m_found[d] = 1'b0; m_pend[d] = 1'b0; m_rearm[d] = 1'b0;
      end
    end else begin
      if (data_valid) begin
        m_log[13'(m_n)] = data;
        m_n++;
      end
      for (int d = 0; d < 2; d++) begin
        hit = data_valid && m_hit(d);
        if (hit && d == 1) m_start[1] = m_n;
        if (hit && m_cnt[d] < 65535) m_cnt[d]++;
        if (!m_found[d]) begin
          if (hit && m_rearm[d]) m_pend[d] = 1'b1;
          if (hit || m_rearm[d]) m_found[d] = 1'b1;
          m_rearm[d] = 1'b0;
        end else if (ack) begin
          m_rearm[d] = m_pend[d] || hit;
          m_found[d] = 1'b0;
          m_pend[d]  = 1'b0;
        end else if (hit) begin
          m_pend[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic expect_eq(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    for (int d = 0; d < 2; d++) begin
      expect_eq(d == 0 ? "model found ov" : "model found no", int'(found[d]), int'(m_found[d]));
      expect_eq(d == 0 ? "model count ov" : "model count no", int'(cnt[d]), m_cnt[d]);
      expect_eq(d == 0 ? "model pend ov" : "model pend no", int'(pend[d]), int'(m_pend[d]));
    end
  endtask

  task automatic cycle();
    m_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic send(input logic [7:0] b);
    data_valid = 1'b1; data = b;
    cycle();
    data_valid = 1'b0;
  endtask

  logic [7:0] pbuf [ML];

  task automatic program_pat(input int n, input int len);
    enable = 1'b0; data_valid = 1'b0; ack = 1'b0;
    cycle();
    for (int i = 0; i < n; i++) begin
      cfg_we = 1'b1; cfg_idx = IW'(i); cfg_byte = pbuf[i];
      cycle();
    end
    cfg_we = 1'b0;
    cfg_len = LW'(len);
  endtask

  task automatic start_scan();
    enable = 1'b1;
    cycle();
  endtask

  task automatic set_bomb();
    pbuf[0] = 8'h62; pbuf[1] = 8'h6F; pbuf[2] = 8'h6D; pbuf[3] = 8'h62;
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 4))
      0, 1:    return 8'h62;
      2, 3:    return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  typedef struct {
    bit         en;
    bit         dv;
    logic [7:0] d;
    bit         ak;
    bit         e_found;
    int         e_cnt;
    bit         e_pend;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 8'h62, 1'b0, 1'b0, 0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 8'h6F, 1'b0, 1'b0, 0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 8'h6D, 1'b0, 1'b0, 0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 8'h62, 1'b0, 1'b1, 1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0};

    m_n = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      expect_eq("reset found", int'(found[d]), 0);
      expect_eq("reset count", int'(cnt[d]), 0);
      expect_eq("reset pend", int'(pend[d]), 0);
    end
    reset_sync = 1'b1;
    cycle();

    // Bomb pattern through the vector table.
    set_bomb();
    program_pat(4, 4);
    for (int i = 0; i < 8; i++) begin
      enable = vecs[i].en; data_valid = vecs[i].dv; data = vecs[i].d; ack = vecs[i].ak;
      cycle();
      for (int d = 0; d < 2; d++) begin
        expect_eq("vec found", int'(found[d]), int'(vecs[i].e_found));
        expect_eq("vec count", int'(cnt[d]), vecs[i].e_cnt);
        expect_eq("vec pend", int'(pend[d]), int'(vecs[i].e_pend));
      end
    end
    data_valid = 1'b0; ack = 1'b0;

    // Idle cycles inside a partial match do not break it.
    program_pat(4, 4);
    start_scan();
    send(8'h62); send(8'h6F);
    repeat (3) cycle();
    send(8'h6D); send(8'h62);
    expect_eq("gap found", int'(found[0]), 1);
    expect_eq("gap count", int'(cnt[0]), 1);

    // A valid foreign symbol does break it.
    program_pat(4, 4);
    start_scan();
    send(8'h62); send(8'h6F); send(8'h00); send(8'h6D); send(8'h62);
    expect_eq("break count ov", int'(cnt[0]), 0);
    expect_eq("break count no", int'(cnt[1]), 0);

    // Overlap versus flush with pattern 62 62.
    pbuf[0] = 8'h62; pbuf[1] = 8'h62;
    program_pat(2, 2);
    start_scan();
    repeat (4) send(8'h62);
    expect_eq("ovl count ov", int'(cnt[0]), 3);
    expect_eq("ovl pend ov", int'(pend[0]), 1);
    expect_eq("ovl count no", int'(cnt[1]), 2);
    expect_eq("ovl pend no", int'(pend[1]), 1);
    expect_eq("ovl found pre-ack", int'(found[0]), 1);
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    expect_eq("rearm gap found", int'(found[0]), 0);
    expect_eq("rearm gap pend", int'(pend[0]), 0);
    cycle();
    expect_eq("rearm found ov", int'(found[0]), 1);
    expect_eq("rearm found no", int'(found[1]), 1);
    expect_eq("rearm pend", int'(pend[0]), 0);

    // Length 0 never matches.
    program_pat(0, 0);
    start_scan();
    repeat (12) send(8'h62);
    expect_eq("len0 count ov", int'(cnt[0]), 0);
    expect_eq("len0 count no", int'(cnt[1]), 0);

    // Length 12 clamps to 8.
    for (int i = 0; i < ML; i++) pbuf[i] = 8'(i + 1);
    program_pat(8, 12);
    start_scan();
    for (int i = 1; i <= 7; i++) send(8'(i));
    expect_eq("clamp found early", int'(found[0]), 0);
    send(8'h08);
    expect_eq("clamp found", int'(found[0]), 1);
    expect_eq("clamp count no", int'(cnt[1]), 1);

    // Config writes while enabled are ignored.
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    cfg_we = 1'b1; cfg_idx = '0; cfg_byte = 8'hFF;
    cycle();
    cfg_we = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'(i));
    expect_eq("cfg locked count ov", int'(cnt[0]), 2);
    expect_eq("cfg locked count no", int'(cnt[1]), 2);

    // Asynchronous reset mid-pattern.
    set_bomb();
    program_pat(4, 4);
    start_scan();
    send(8'h62); send(8'h6F); send(8'h6D); send(8'h62);
    send(8'h62); send(8'h6F); send(8'h6D);
    expect_eq("pre-reset found", int'(found[0]), 1);
    reset_sync = 1'b0;
    enable = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      expect_eq("async reset found", int'(found[d]), 0);
      expect_eq("async reset count", int'(cnt[d]), 0);
      expect_eq("async reset pend", int'(pend[d]), 0);
    end
    m_reset();
    cycle();
    reset_sync = 1'b1;
    set_bomb();
    program_pat(4, 4);
    start_scan();
    send(8'h62);
    expect_eq("post-reset found", int'(found[0]), 0);
    expect_eq("post-reset count", int'(cnt[0]), 0);

    // Randomised traffic against the model.
    for (int it = 0; it < 3000; it++) begin
      if (!enable) begin
        cfg_we   = 1'($urandom_range(0, 1));
        cfg_idx  = IW'($urandom_range(0, ML - 1));
        cfg_byte = pick();
        cfg_len  = ($urandom_range(0, 9) == 0) ? LW'($urandom_range(0, 12))
                                                : LW'($urandom_range(1, 3));
        if ($urandom_range(0, 3) == 0) enable = 1'b1;
      end else begin
        cfg_we   = ($urandom_range(0, 7) == 0);
        cfg_idx  = IW'($urandom_range(0, ML - 1));
        cfg_byte = pick();
        if ($urandom_range(0, 99) == 0) enable = 1'b0;
      end
      data_valid = ($urandom_range(0, 3) != 0);
      data       = pick();
      ack        = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
